// File: rtl/control_sequencer.sv
// Hardwired Moore sequencer for the Mini SRC datapath.
// Fetch F0-F3, execute T4-T9, HALTED until cleared.
module control_sequencer #(
   parameter logic [4:0] RESET_PC_SEL = 5'd20
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        stop,
   input  logic [31:0] ir,
   input  logic        con_out,
   output logic        run,
   output logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO,
   output logic        e_MDR, e_MAR, e_OutPort, e_InPort,
   output logic        e_RA, e_CON_FF,
   output logic        incPC, ram_read, ram_write, MDR_read, imm_sel,
   output logic        Gra, Grb, Grc, e_Rin, e_Rout, BAout,
   output logic [4:0]  BusDataSelect,
   output logic [3:0]  ALU_op
);

   typedef enum logic [3:0] {
      F0, F1, F2, F3, T4, T5, T6, T7, T8, T9, HALTED
   } state_e;

   state_e state_q, state_d;

   logic [4:0] op;
   logic [3:0] ra, rb, rc;
   assign op = ir[31:27];
   assign ra = ir[26:23];
   assign rb = ir[22:19];
   assign rc = ir[18:15];

   logic unused_ir;
   assign unused_ir = ^ir[14:0];

   logic c_alu, c_imm, c_ldi, c_ld, c_st, c_md, c_nn;
   logic c_br, c_jr, c_jal, c_in, c_out, c_mfhi, c_mflo, c_halt;
   logic c_addr;
   assign c_ld   = (op == 5'd0);
   assign c_ldi  = (op == 5'd1);
   assign c_st   = (op == 5'd2);
   assign c_alu  = (op >= 5'd3) && (op <= 5'd11);
   assign c_imm  = (op >= 5'd12) && (op <= 5'd14);
   assign c_md   = (op == 5'd15) || (op == 5'd16);
   assign c_nn   = (op == 5'd17) || (op == 5'd18);
   assign c_br   = (op == 5'd19);
   assign c_jr   = (op == 5'd20);
   assign c_jal  = (op == 5'd21);
   assign c_in   = (op == 5'd22);
   assign c_out  = (op == 5'd23);
   assign c_mfhi = (op == 5'd24);
   assign c_mflo = (op == 5'd25);
   assign c_halt = (op == 5'd27);
   assign c_addr = c_ld | c_ldi | c_st;

   logic [3:0] alu_code;
   logic [3:0] last_st;

   // Opcode to ALU function and index of the final execute state
   always_comb begin
      alu_code = 4'd0;
      last_st  = 4'd3;
      unique case (op)
         5'd3:  alu_code = 4'd0;
         5'd4:  alu_code = 4'd1;
         5'd5:  alu_code = 4'd2;
         5'd6:  alu_code = 4'd3;
         5'd7:  alu_code = 4'd7;
         5'd8:  alu_code = 4'd8;
         5'd9:  alu_code = 4'd4;
         5'd10: alu_code = 4'd5;
         5'd11: alu_code = 4'd6;
         5'd12: alu_code = 4'd0;
         5'd13: alu_code = 4'd2;
         5'd14: alu_code = 4'd3;
         5'd15: alu_code = 4'd10;
         5'd16: alu_code = 4'd9;
         5'd17: alu_code = 4'd11;
         5'd18: alu_code = 4'd12;
         default: alu_code = 4'd0;
      endcase
      if (c_alu | c_imm | c_ldi)          last_st = 4'd6;
      else if (c_ld)                      last_st = 4'd9;
      else if (c_st | c_md | c_br)        last_st = 4'd7;
      else if (c_nn | c_jal | c_in)       last_st = 4'd5;
      else if (c_jr | c_out | c_mfhi | c_mflo) last_st = 4'd4;
      else                                last_st = 4'd3;
   end

   // State register with synchronous active-low clear
   always_ff @(posedge clock) begin
      if (!clear) state_q <= F0;
      else        state_q <= state_d;
   end

   // Next-state sequencing
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         F0: state_d = F1;
         F1: state_d = F2;
         F2: state_d = F3;
         F3: begin
            if (c_halt)                state_d = HALTED;
            else if (last_st == 4'd3)  state_d = F0;
            else                       state_d = T4;
         end
         HALTED: state_d = HALTED;
         default: begin
            if (state_q == last_st) state_d = stop ? HALTED : F0;
            else                    state_d = state_e'(state_q + 4'd1);
         end
      endcase
   end

   // Moore output decode; everything is forced low while clear is asserted
   always_comb begin
      {e_PC, e_IR, e_Y, e_Z, e_HI, e_LO} = '0;
      {e_MDR, e_MAR, e_OutPort, e_InPort, e_RA, e_CON_FF} = '0;
      {incPC, ram_read, ram_write, MDR_read, imm_sel} = '0;
      {Gra, Grb, Grc, e_Rin, e_Rout, BAout} = '0;
      BusDataSelect = 5'd0;
      ALU_op        = 4'd0;
      run           = clear && (state_q != HALTED);
      if (clear) begin
         unique case (state_q)
            F0: begin
               BusDataSelect = RESET_PC_SEL;
               e_MAR = 1'b1;
               incPC = 1'b1;
            end
            F1: ram_read = 1'b1;
            F2: begin
               ram_read = 1'b1;
               MDR_read = 1'b1;
               e_MDR    = 1'b1;
            end
            F3: begin
               BusDataSelect = 5'd21;
               e_IR = 1'b1;
            end
            T4: begin
               if (c_alu | c_imm | c_addr) begin
                  BusDataSelect = {1'b0, rb};
                  e_Rout = 1'b1; Grb = 1'b1; e_Y = 1'b1;
                  BAout = c_addr;
               end else if (c_md) begin
                  BusDataSelect = {1'b0, ra};
                  e_Rout = 1'b1; Gra = 1'b1; e_Y = 1'b1;
               end else if (c_nn) begin
                  BusDataSelect = {1'b0, rb};
                  e_Rout = 1'b1; Grb = 1'b1;
                  ALU_op = alu_code; e_Z = 1'b1;
               end else if (c_br) begin
                  BusDataSelect = {1'b0, ra};
                  e_Rout = 1'b1; Gra = 1'b1;
                  e_RA = 1'b1; e_CON_FF = 1'b1;
               end else if (c_jr | c_out) begin
                  BusDataSelect = {1'b0, ra};
                  e_Rout = 1'b1; Gra = 1'b1;
                  e_PC = c_jr; e_OutPort = c_out;
               end else if (c_jal) begin
                  BusDataSelect = RESET_PC_SEL;
                  Grb = 1'b1; e_Rin = 1'b1;
               end else if (c_in) begin
                  e_InPort = 1'b1;
               end else if (c_mfhi | c_mflo) begin
                  BusDataSelect = c_mfhi ? 5'd16 : 5'd17;
                  Gra = 1'b1; e_Rin = 1'b1;
               end
            end
            T5: begin
               if (c_alu) begin
                  BusDataSelect = {1'b0, rc};
                  e_Rout = 1'b1; Grc = 1'b1;
                  ALU_op = alu_code; e_Z = 1'b1;
               end else if (c_imm | c_addr) begin
                  imm_sel = 1'b1; e_Z = 1'b1;
                  ALU_op = c_imm ? alu_code : 4'd0;
               end else if (c_md) begin
                  BusDataSelect = {1'b0, rb};
                  e_Rout = 1'b1; Grb = 1'b1;
                  ALU_op = alu_code; e_Z = 1'b1;
               end else if (c_nn | c_in) begin
                  BusDataSelect = c_nn ? 5'd19 : 5'd22;
                  Gra = 1'b1; e_Rin = 1'b1;
               end else if (c_br) begin
                  BusDataSelect = RESET_PC_SEL;
                  e_Y = 1'b1;
               end else if (c_jal) begin
                  BusDataSelect = {1'b0, ra};
                  e_Rout = 1'b1; Gra = 1'b1; e_PC = 1'b1;
               end
            end
            T6: begin
               if (c_alu | c_imm | c_ldi) begin
                  BusDataSelect = 5'd19;
                  Gra = 1'b1; e_Rin = 1'b1;
               end else if (c_ld | c_st) begin
                  BusDataSelect = 5'd19; e_MAR = 1'b1;
               end else if (c_md) begin
                  BusDataSelect = 5'd19; e_LO = 1'b1;
               end else if (c_br) begin
                  imm_sel = 1'b1; e_Z = 1'b1;
               end
            end
            T7: begin
               if (c_ld) begin
                  ram_read = 1'b1;
               end else if (c_st) begin
                  BusDataSelect = {1'b0, ra};
                  e_Rout = 1'b1; Gra = 1'b1; ram_write = 1'b1;
               end else if (c_md) begin
                  BusDataSelect = 5'd18; e_HI = 1'b1;
               end else if (c_br && con_out) begin
                  BusDataSelect = 5'd19; e_PC = 1'b1;
               end
            end
            T8: begin
               if (c_ld) begin
                  ram_read = 1'b1; MDR_read = 1'b1; e_MDR = 1'b1;
               end
            end
            T9: begin
               if (c_ld) begin
                  BusDataSelect = 5'd21;
                  Gra = 1'b1; e_Rin = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed
// instructions, expected control words queued per cycle.
module tb_control_sequencer;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic        stop = 1'b0;
   logic [31:0] ir = '0;
   logic        con_out = 1'b0;
   logic        run;
   logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO;
   logic        e_MDR, e_MAR, e_OutPort, e_InPort, e_RA, e_CON_FF;
   logic        incPC, ram_read, ram_write, MDR_read, imm_sel;
   logic        Gra, Grb, Grc, e_Rin, e_Rout, BAout;
   logic [4:0]  BusDataSelect;
   logic [3:0]  ALU_op;

   control_sequencer #(.RESET_PC_SEL(5'd20)) dut (
      .clock(clock), .clear(clear), .stop(stop), .ir(ir),
      .con_out(con_out), .run(run),
      .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z),
      .e_HI(e_HI), .e_LO(e_LO), .e_MDR(e_MDR), .e_MAR(e_MAR),
      .e_OutPort(e_OutPort), .e_InPort(e_InPort),
      .e_RA(e_RA), .e_CON_FF(e_CON_FF),
      .incPC(incPC), .ram_read(ram_read), .ram_write(ram_write),
      .MDR_read(MDR_read), .imm_sel(imm_sel),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .e_Rin(e_Rin),
      .e_Rout(e_Rout), .BAout(BAout),
      .BusDataSelect(BusDataSelect), .ALU_op(ALU_op)
   );

   always #5 clock = ~clock;

   typedef logic [32:0] cw_t;
   localparam cw_t RUN   = cw_t'(1) << 32;
   localparam cw_t EPC   = cw_t'(1) << 31;
   localparam cw_t EIR   = cw_t'(1) << 30;
   localparam cw_t EY    = cw_t'(1) << 29;
   localparam cw_t EZ    = cw_t'(1) << 28;
   localparam cw_t EHI   = cw_t'(1) << 27;
   localparam cw_t ELO   = cw_t'(1) << 26;
   localparam cw_t EMDR  = cw_t'(1) << 25;
   localparam cw_t EMAR  = cw_t'(1) << 24;
   localparam cw_t EOUT  = cw_t'(1) << 23;
   localparam cw_t EIN   = cw_t'(1) << 22;
   localparam cw_t ERA   = cw_t'(1) << 21;
   localparam cw_t ECON  = cw_t'(1) << 20;
   localparam cw_t INC   = cw_t'(1) << 19;
   localparam cw_t RRD   = cw_t'(1) << 18;
   localparam cw_t RWR   = cw_t'(1) << 17;
   localparam cw_t MRD   = cw_t'(1) << 16;
   localparam cw_t IMM   = cw_t'(1) << 15;
   localparam cw_t GRA   = cw_t'(1) << 14;
   localparam cw_t GRB   = cw_t'(1) << 13;
   localparam cw_t GRC   = cw_t'(1) << 12;
   localparam cw_t ERIN  = cw_t'(1) << 11;
   localparam cw_t EROUT = cw_t'(1) << 10;
   localparam cw_t BAO   = cw_t'(1) << 9;

   cw_t obs;
   assign obs = {run, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO,
                 e_MDR, e_MAR, e_OutPort, e_InPort, e_RA, e_CON_FF,
                 incPC, ram_read, ram_write, MDR_read, imm_sel,
                 Gra, Grb, Grc, e_Rin, e_Rout, BAout,
                 BusDataSelect, ALU_op};

   function automatic cw_t S(input int v);
      return cw_t'(v[4:0]) << 4;
   endfunction

   function automatic cw_t A(input int v);
      return cw_t'(v[3:0]);
   endfunction

   function automatic logic [31:0] mk(input int o, input int a,
                                      input int b, input int c);
      return {o[4:0], a[3:0], b[3:0], c[3:0], 15'h0010};
   endfunction

   cw_t   exp_q[$];
   string tag_q[$];
   int    total = 0;
   int    bad = 0;

   // Monitor: one expected control word per cycle, sampled mid-cycle
   initial begin
      cw_t e;
      string t;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            total++;
            if (obs !== e) begin
               bad++;
               $display("FAIL %s got=%h exp=%h", t, obs, e);
            end
         end
      end
   end

   task automatic cy(input string t, input cw_t e);
      exp_q.push_back(e);
      tag_q.push_back(t);
      @(posedge clock);
      #1;
   endtask

   task automatic fetch(input string n, input logic [31:0] w);
      ir = w;
      cy({n, ".F0"}, RUN | EMAR | INC | S(20));
      cy({n, ".F1"}, RUN | RRD);
      cy({n, ".F2"}, RUN | RRD | MRD | EMDR);
      cy({n, ".F3"}, RUN | EIR | S(21));
   endtask

   initial begin
      @(posedge clock);
      #1;
      clear = 1'b0;
      cy("rst0", '0);
      cy("rst1", '0);
      clear = 1'b1;

      fetch("add", mk(3, 3, 1, 2));
      cy("add.T4", RUN | S(1) | EROUT | GRB | EY);
      cy("add.T5", RUN | S(2) | EROUT | GRC | EZ | A(0));
      cy("add.T6", RUN | S(19) | GRA | ERIN);

      fetch("shr", mk(9, 1, 2, 3));
      cy("shr.T4", RUN | S(2) | EROUT | GRB | EY);
      cy("shr.T5", RUN | S(3) | EROUT | GRC | EZ | A(4));
      cy("shr.T6", RUN | S(19) | GRA | ERIN);

      fetch("ld", mk(0, 2, 0, 0));
      cy("ld.T4", RUN | S(0) | EROUT | GRB | EY | BAO);
      cy("ld.T5", RUN | IMM | EZ | A(0));
      cy("ld.T6", RUN | S(19) | EMAR);
      cy("ld.T7", RUN | RRD);
      cy("ld.T8", RUN | RRD | MRD | EMDR);
      cy("ld.T9", RUN | S(21) | GRA | ERIN);

      con_out = 1'b0;
      fetch("br0", mk(19, 4, 2, 0));
      cy("br0.T4", RUN | S(4) | EROUT | GRA | ERA | ECON);
      cy("br0.T5", RUN | S(20) | EY);
      cy("br0.T6", RUN | IMM | EZ | A(0));
      cy("br0.T7", RUN);

      fetch("br1", mk(19, 4, 2, 0));
      cy("br1.T4", RUN | S(4) | EROUT | GRA | ERA | ECON);
      cy("br1.T5", RUN | S(20) | EY);
      cy("br1.T6", RUN | IMM | EZ | A(0));
      con_out = 1'b1;
      cy("br1.T7", RUN | S(19) | EPC);
      con_out = 1'b0;

      fetch("mul", mk(16, 4, 5, 0));
      cy("mul.T4", RUN | S(4) | EROUT | GRA | EY);
      cy("mul.T5", RUN | S(5) | EROUT | GRB | EZ | A(9));
      cy("mul.T6", RUN | S(19) | ELO);
      cy("mul.T7", RUN | S(18) | EHI);

      fetch("jal", mk(21, 6, 15, 0));
      cy("jal.T4", RUN | S(20) | GRB | ERIN);
      cy("jal.T5", RUN | S(6) | EROUT | GRA | EPC);

      fetch("mfhi", mk(24, 7, 0, 0));
      cy("mfhi.T4", RUN | S(16) | GRA | ERIN);

      fetch("nop", mk(26, 0, 0, 0));
      fetch("undef", mk(31, 0, 0, 0));

      fetch("halt", mk(27, 0, 0, 0));
      cy("halt.H0", '0);
      cy("halt.H1", '0);
      clear = 1'b0;
      cy("halt.clr", '0);
      clear = 1'b1;

      fetch("stp", mk(3, 3, 1, 2));
      cy("stp.T4", RUN | S(1) | EROUT | GRB | EY);
      cy("stp.T5", RUN | S(2) | EROUT | GRC | EZ | A(0));
      stop = 1'b1;
      cy("stp.T6", RUN | S(19) | GRA | ERIN);
      stop = 1'b0;
      cy("stp.H0", '0);
      cy("stp.H1", '0);
      clear = 1'b0;
      cy("stp.clr", '0);
      clear = 1'b1;

      fetch("ldc", mk(0, 2, 0, 0));
      cy("ldc.T4", RUN | S(0) | EROUT | GRB | EY | BAO);
      clear = 1'b0;
      cy("ldc.T5clr", '0);
      clear = 1'b1;
      fetch("after", mk(26, 0, 0, 0));
      cy("after.F0", RUN | EMAR | INC | S(20));

      @(negedge clock);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d exp=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
